// File: rtl/c499_sec_scheduler.sv
// c499_sec_scheduler: serial key loader and round-robin arbiter sharing one c499 SEC core between two requesters
module c499_sec_scheduler #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 8,
  parameter int KEY_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_sin,
  input  logic              key_shift,
  output logic              key_valid,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [CHK_W-1:0]  req0_chk,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [CHK_W-1:0]  req1_chk,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_corrected,
  output logic [CNT_W-1:0]  corr_count,
  output logic [DATA_W-1:0] core_din,
  output logic [CHK_W-1:0]  core_chk,
  output logic              core_en,
  output logic [KEY_W-1:0]  core_key,
  input  logic [DATA_W-1:0] core_dout
);
  localparam int KCW = $clog2(KEY_W + 1);
  typedef enum logic [2:0] {KEY_LOAD, IDLE, ISSUE, CAPTURE, RESPOND} state_t;
  state_t state, state_nx;
  logic [KCW-1:0] kcnt;
  logic rr, gid, accept_ok, fire, rekey, kload, kdone, corr;
  always_comb begin
    gid        = (req0_valid && req1_valid) ? !rr : req1_valid;
    rekey      = state == IDLE && key_shift;
    kload      = key_shift && (state == KEY_LOAD || state == IDLE);
    kdone      = state == KEY_LOAD && key_shift && kcnt == KCW'(KEY_W - 1);
    accept_ok  = state == IDLE && key_valid && !key_shift;
    req0_ready = accept_ok && req0_valid && !gid;
    req1_ready = accept_ok && req1_valid && gid;
    fire       = req0_ready || req1_ready;
    corr       = core_dout != core_din;
    state_nx   = state;
    case (state)
      KEY_LOAD: state_nx = kdone ? IDLE : KEY_LOAD;
      IDLE:     state_nx = rekey ? KEY_LOAD : fire ? ISSUE : IDLE;
      ISSUE:    state_nx = CAPTURE;
      CAPTURE:  state_nx = RESPOND;
      RESPOND:  state_nx = rsp_ready ? IDLE : RESPOND;
      default:  state_nx = KEY_LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= KEY_LOAD;
    else state <= state_nx;
  // rr doubles as the id of the word in flight, since it is updated at the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_key      <= '0;
      kcnt          <= '0;
      key_valid     <= 1'b0;
      rr            <= 1'b1;
      core_din      <= '0;
      core_chk      <= '0;
      core_en       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_data      <= '0;
      rsp_corrected <= 1'b0;
      corr_count    <= '0;
    end else begin
      if (kload) begin
        core_key  <= {key_sin, core_key[KEY_W-1:1]};
        key_valid <= kdone;
        kcnt      <= kdone ? '0 : rekey ? KCW'(1) : kcnt + KCW'(1);
      end
      if (fire) begin
        core_din <= gid ? req1_data : req0_data;
        core_chk <= gid ? req1_chk : req0_chk;
        core_en  <= 1'b1;
        rr       <= gid;
      end
      if (state == CAPTURE) begin
        rsp_data      <= core_dout;
        rsp_corrected <= corr;
        rsp_id        <= rr;
        rsp_valid     <= 1'b1;
        core_en       <= 1'b0;
        if (corr && !(&corr_count)) corr_count <= corr_count + CNT_W'(1);
      end
      if (state == RESPOND && rsp_ready) begin
        rsp_valid <= 1'b0;
        core_en   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_c499_sec_scheduler.sv
// tb_c499_sec_scheduler: scoreboard bench with a behavioural core model and arbitration/latency/saturation reference
module tb_c499_sec_scheduler;
  localparam int DW = 32, CW = 8, KW = 8, NW = 2;
  logic clk = 0, rst_n = 0, key_sin = 0, key_shift = 0, key_valid;
  logic req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
  logic [DW-1:0] req0_data = 0, req1_data = 0;
  logic [CW-1:0] req0_chk = 0, req1_chk = 0;
  logic rsp_valid, rsp_ready = 1, rsp_id, rsp_corrected, core_en;
  logic [DW-1:0] rsp_data, core_din, core_dout;
  logic [NW-1:0] corr_count;
  logic [CW-1:0] core_chk;
  logic [KW-1:0] core_key;
  int mode = 0, compared = 0, mismatched = 0, cyc = 0, mcount = 0, rise = 0;
  bit last = 1;
  bit glog[$];
  typedef struct {logic id; logic [DW-1:0] data; logic corr; int rise;} exp_t;
  exp_t q[$];

  c499_sec_scheduler #(.DATA_W(DW), .CHK_W(CW), .KEY_W(KW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .key_sin(key_sin), .key_shift(key_shift), .key_valid(key_valid),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_chk(req0_chk),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_chk(req1_chk),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_corrected(rsp_corrected), .corr_count(corr_count), .core_din(core_din), .core_chk(core_chk),
    .core_en(core_en), .core_key(core_key), .core_dout(core_dout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // core stand-in: mode 0 echoes, mode 1 flips bit 0, mode 2 flips a data-selected bit on odd words
  function automatic logic [DW-1:0] core_fn(input int m, input logic [DW-1:0] d);
    return m == 0 ? d : m == 1 ? d ^ 32'h1 : (d[0] ? d ^ (32'h1 << d[5:1]) : d);
  endfunction
  assign core_dout = core_fn(mode, core_din);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic g;
  logic [DW-1:0] d;
  always @(negedge clk) if (rst_n) begin
    chk("both_ready", req0_ready & req1_ready, 0);
    if (rsp_valid || !key_valid) chk("ready_blocked", req0_ready | req1_ready, 0);
    if (req0_ready | req1_ready) begin
      g = (req0_valid && req1_valid) ? !last : req1_valid;
      chk("grant_id", req1_ready, g);
      last = g;
      glog.push_back(g);
      d = g ? req1_data : req0_data;
      q.push_back('{g, core_fn(mode, d), core_fn(mode, d) != d, cyc + 3});
    end
  end

  logic pv = 0, pstall = 0, pid, pc;
  logic [DW-1:0] pd;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 0;
      pstall = 0;
    end else begin
      if (rsp_valid && !pv) rise = cyc;
      if (pstall) begin
        chk("stall_valid", rsp_valid, 1);
        chk("stall_hold", {rsp_id, rsp_corrected, rsp_data}, {pid, pc, pd});
      end
      if (rsp_valid && rsp_ready) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_rsp: got response id %0d with empty scoreboard", rsp_id);
        end else begin
          e = q.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_corrected", rsp_corrected, e.corr);
          chk("latency", rise, e.rise);
          mcount = e.corr ? (mcount < 3 ? mcount + 1 : 3) : mcount;
          chk("corr_count", corr_count, mcount);
        end
      end
      pv = rsp_valid;
      pstall = rsp_valid && !rsp_ready;
      pd = rsp_data;
      pid = rsp_id;
      pc = rsp_corrected;
    end
  end

  task automatic shift_key(input logic [KW-1:0] v);
    for (int i = 0; i < KW; i++) begin
      key_shift = 1;
      key_sin = v[i];
      @(negedge clk);
      chk("kv_early", key_valid, 0);
      chk("ready_early", req0_ready | req1_ready, 0);
      @(posedge clk); #2;
    end
    key_shift = 0;
    chk("key_valid", key_valid, 1);
    chk("core_key", core_key, v);
  endtask

  task automatic wait_hs(input bit id);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
      @(posedge clk); #2;
    end
    if (id) req1_valid = 0; else req0_valid = 0;
    chk("hs_timeout", got, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = q.size() == 0 && !rsp_valid;
    end
    @(posedge clk); #2;
    chk("idle_timeout", done, 1);
  endtask

  task automatic do_req(input bit id, input logic [DW-1:0] dat);
    if (id) begin req1_data = dat; req1_chk = CW'($urandom); req1_valid = 1; end
    else begin req0_data = dat; req0_chk = CW'($urandom); req0_valid = 1; end
    wait_hs(id);
    wait_idle();
  endtask

  initial begin
    bit f0, f1, got;
    repeat (2) @(posedge clk); #2;
    chk("rst_key_valid", key_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_corr_count", corr_count, 0);
    chk("rst_core_key", core_key, 0);
    rst_n = 1;
    req0_valid = 1;
    shift_key(8'hA5);
    wait_hs(0);
    wait_idle();
    do_req(1, $urandom);
    glog.delete();
    req0_data = $urandom; req1_data = $urandom; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 100 && glog.size() < 4; i++) begin
      @(negedge clk);
      f0 = req0_ready; f1 = req1_ready;
      @(posedge clk); #2;
      if (f0) req0_data = $urandom;
      if (f1) req1_data = $urandom;
    end
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    chk("rr_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("rr_order", glog[i], i % 2);
    mode = 1;
    do_req(0, 32'h1234_5678);
    chk("flip_data", rsp_data, 32'h1234_5679);
    chk("flip_corrected", rsp_corrected, 1);
    chk("flip_count", corr_count, 1);
    for (int i = 0; i < 4; i++) do_req(i % 2, $urandom);
    chk("sat_count", corr_count, 3);
    mode = 0;
    rsp_ready = 0;
    req0_data = $urandom; req0_valid = 1;
    wait_hs(0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = rsp_valid; end
    chk("stall_rsp_timeout", got, 1);
    @(posedge clk); #2;
    req1_data = $urandom; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      key_shift = 1; key_sin = 1'($urandom);
      @(negedge clk);
      chk("stall_key", core_key, 8'hA5);
      @(posedge clk); #2;
    end
    key_shift = 0;
    chk("stall_key_after", core_key, 8'hA5);
    rsp_ready = 1;
    wait_hs(1);
    wait_idle();
    mode = 2;
    f0 = 0; f1 = 0;
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom % 4) != 0;
      if (!req0_valid || f0) begin req0_valid = 1'($urandom); req0_data = $urandom; req0_chk = CW'($urandom); end
      if (!req1_valid || f1) begin req1_valid = 1'($urandom); req1_data = $urandom; req1_chk = CW'($urandom); end
      @(negedge clk);
      f0 = req0_ready; f1 = req1_ready;
      @(posedge clk); #2;
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    wait_idle();
    mode = 0;
    req0_data = $urandom; req0_valid = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = req0_ready; end
    chk("pre_reset_hs", got, 1);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 0;
    q.delete(); last = 1; mcount = 0;
    #1;
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_key_valid", key_valid, 0);
    chk("async_core_en", core_en, 0);
    @(posedge clk); #2;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_ready", req0_ready, 0);
      @(posedge clk); #2;
    end
    shift_key(8'h3C);
    wait_hs(0);
    wait_idle();
    chk("final_queue", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
